// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of the pipelined DLX.
//
// Owns the PC, issues instruction-memory requests over a req/ack handshake
// and loads the IF/ID register with {instruction, PC+4, valid}. It honours
// stall from the hazard unit and redirects from ID (jumps) and EX (taken
// branches). There is no delay slot, so the word after a taken jump or branch
// is always squashed.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   i_req, i_address         fetch request / word-aligned byte address
//   i_ack, i_data_read       memory acknowledge / instruction word
//   stall                    hold IF/ID and PC
//   id_redirect, id_target   jump resolved in ID
//   ex_redirect, ex_target   taken branch resolved in EX (wins over ID)
//   if_id_instr, if_id_pc4,  IF/ID pipeline register to the decoder
//   if_id_valid
//   perf_fetched,            performance counters; only built when the
//   perf_stall_cycles        FETCH_PERF_EN macro is defined, else tied to 0
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        i_req,
   output logic [31:0] i_address,
   input  logic        i_ack,
   input  logic [31:0] i_data_read,
   input  logic        stall,
   input  logic        id_redirect,
   input  logic [31:0] id_target,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cycles
);

   typedef enum logic [1:0] {FETCH, DISCARD, HELD} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] pending_reg, pending_next;
   logic [31:0] skid_instr_reg, skid_instr_next;
   logic [31:0] skid_pc4_reg, skid_pc4_next;
   logic [31:0] if_id_instr_reg, if_id_instr_next;
   logic [31:0] if_id_pc4_reg, if_id_pc4_next;
   logic        if_id_valid_reg, if_id_valid_next;

   logic        redir;
   logic [31:0] redir_target;
   logic [31:0] pc_plus4;

   // A jump in ID is ignored during a stall; it is re-presented afterwards.
   assign redir        = ex_redirect | (id_redirect & ~stall);
   assign redir_target = (ex_redirect ? ex_target : id_target) & 32'hFFFF_FFFC;
   assign pc_plus4     = pc_reg + 32'd4;

   // Request is dropped while reset is asserted and while the skid holds a word.
   assign i_req       = reset_n & (state_reg != HELD);
   assign i_address   = pc_reg;
   assign if_id_instr = if_id_instr_reg;
   assign if_id_pc4   = if_id_pc4_reg;
   assign if_id_valid = if_id_valid_reg;

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      pending_next     = pending_reg;
      skid_instr_next  = skid_instr_reg;
      skid_pc4_next    = skid_pc4_reg;
      if_id_instr_next = if_id_instr_reg;
      if_id_pc4_next   = if_id_pc4_reg;
      if_id_valid_next = if_id_valid_reg;

      case (state_reg)
         FETCH: begin
            if (redir) begin
               if_id_instr_next = NOP_WORD;
               if_id_pc4_next   = 32'd0;
               if_id_valid_next = 1'b0;
               if (i_ack) begin
                  pc_next = redir_target;
               end else begin
                  // The outstanding request must still complete before the
                  // address may change; its data will be dropped.
                  pending_next = redir_target;
                  state_next   = DISCARD;
               end
            end else if (i_ack) begin
               pc_next = pc_plus4;
               if (stall) begin
                  skid_instr_next = i_data_read;
                  skid_pc4_next   = pc_plus4;
                  state_next      = HELD;
               end else begin
                  if_id_instr_next = i_data_read;
                  if_id_pc4_next   = pc_plus4;
                  if_id_valid_next = 1'b1;
               end
            end else if (!stall) begin
               if_id_instr_next = NOP_WORD;
               if_id_pc4_next   = 32'd0;
               if_id_valid_next = 1'b0;
            end
         end

         DISCARD: begin
            if_id_instr_next = NOP_WORD;
            if_id_pc4_next   = 32'd0;
            if_id_valid_next = 1'b0;
            if (redir) begin
               pending_next = redir_target;
            end
            if (i_ack) begin
               pc_next    = redir ? redir_target : pending_reg;
               state_next = FETCH;
            end
         end

         HELD: begin
            if (redir) begin
               // The skid word is on the wrong path of the redirect.
               pc_next          = redir_target;
               if_id_instr_next = NOP_WORD;
               if_id_pc4_next   = 32'd0;
               if_id_valid_next = 1'b0;
               state_next       = FETCH;
            end else if (!stall) begin
               if_id_instr_next = skid_instr_reg;
               if_id_pc4_next   = skid_pc4_reg;
               if_id_valid_next = 1'b1;
               state_next       = FETCH;
            end
         end

         default: begin
            state_next = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= FETCH;
         pc_reg          <= RESET_PC;
         pending_reg     <= 32'd0;
         skid_instr_reg  <= 32'd0;
         skid_pc4_reg    <= 32'd0;
         if_id_instr_reg <= NOP_WORD;
         if_id_pc4_reg   <= 32'd0;
         if_id_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         pending_reg     <= pending_next;
         skid_instr_reg  <= skid_instr_next;
         skid_pc4_reg    <= skid_pc4_next;
         if_id_instr_reg <= if_id_instr_next;
         if_id_pc4_reg   <= if_id_pc4_next;
         if_id_valid_reg <= if_id_valid_next;
      end
   end

`ifdef FETCH_PERF_EN
   logic        load_valid;
   logic [31:0] perf_fetched_reg;
   logic [31:0] perf_stall_reg;

   // Exactly the conditions under which IF/ID is loaded with valid=1.
   assign load_valid = ((state_reg == FETCH) & i_ack & ~redir & ~stall) |
                       ((state_reg == HELD) & ~redir & ~stall);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched_reg <= 32'd0;
         perf_stall_reg   <= 32'd0;
      end else begin
         if (load_valid) perf_fetched_reg <= perf_fetched_reg + 32'd1;
         if (stall)      perf_stall_reg   <= perf_stall_reg + 32'd1;
      end
   end

   assign perf_fetched      = perf_fetched_reg;
   assign perf_stall_cycles = perf_stall_reg;
`else
   assign perf_fetched      = 32'd0;
   assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
// Directed per-cycle vector table, a perf-counter sequence, then randomized
// traffic checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req;
   logic [31:0] i_address;
   logic        i_ack = 1'b0;
   logic [31:0] i_data_read;
   logic        stall = 1'b0;
   logic        id_redirect = 1'b0;
   logic [31:0] id_target = 32'd0;
   logic        ex_redirect = 1'b0;
   logic [31:0] ex_target = 32'd0;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cycles;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   assign i_data_read = mem_word(i_address);

   fetch_stage dut (
      .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_address(i_address),
      .i_ack(i_ack), .i_data_read(i_data_read), .stall(stall),
      .id_redirect(id_redirect), .id_target(id_target),
      .ex_redirect(ex_redirect), .ex_target(ex_target),
      .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
      .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic a, input logic s, input logic idr, input logic [31:0] idt,
                        input logic exr, input logic [31:0] ext);
      i_ack = a; stall = s; id_redirect = idr; id_target = idt;
      ex_redirect = exr; ex_target = ext;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Directed vectors: inputs for one cycle, the request expected during that
   // cycle, and the IF/ID contents expected after its clock edge.
   typedef struct {
      logic        ack;
      logic        stl;
      logic        idr;
      logic [31:0] idt;
      logic        exr;
      logic [31:0] ext;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc4;
   } vec_t;

   function automatic vec_t mk(input logic a, input logic s, input logic idr, input logic [31:0] idt,
                               input logic exr, input logic [31:0] ext, input logic rq,
                               input logic [31:0] ad, input logic v, input logic [31:0] p4);
      vec_t r;
      r.ack = a; r.stl = s; r.idr = idr; r.idt = idt; r.exr = exr; r.ext = ext;
      r.req = rq; r.addr = ad; r.valid = v; r.pc4 = p4;
      return r;
   endfunction

   // Reference model state (transaction level).
   logic [31:0] m_pc;
   logic [31:0] m_instr, m_pc4;
   logic        m_valid;
   logic [31:0] m_skid_q[$];    // fetched-but-not-issued word addresses
   logic        m_squash;       // an already-redirected fetch is still outstanding
   logic [31:0] m_tgt;
   int          m_fetched, m_stalls;

   task automatic model_reset();
      m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
      m_skid_q.delete(); m_squash = 1'b0; m_tgt = 32'd0;
      m_fetched = 0; m_stalls = 0;
   endtask

   task automatic model_bubble();
      m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
   endtask

   task automatic model_issue(input logic [31:0] a);
      m_instr = mem_word(a); m_pc4 = a + 32'd4; m_valid = 1'b1; m_fetched++;
   endtask

   task automatic model_step(input logic a, input logic s, input logic idr, input logic [31:0] idt,
                             input logic exr, input logic [31:0] ext);
      logic        rd;
      logic [31:0] t;
      logic [31:0] w;
      rd = exr | (idr & ~s);
      t  = (exr ? ext : idt) & 32'hFFFF_FFFC;
      if (s) m_stalls++;
      if (m_skid_q.size() != 0) begin
         if (rd) begin
            m_skid_q.delete(); m_pc = t; model_bubble();
         end else if (!s) begin
            w = m_skid_q.pop_front(); model_issue(w);
         end
      end else if (m_squash) begin
         if (rd) m_tgt = t;
         if (a) begin m_pc = m_tgt; m_squash = 1'b0; end
         model_bubble();
      end else if (rd) begin
         if (a) m_pc = t;
         else begin m_squash = 1'b1; m_tgt = t; end
         model_bubble();
      end else if (a) begin
         if (s) m_skid_q.push_back(m_pc);
         else model_issue(m_pc);
         m_pc = m_pc + 32'd4;
      end else if (!s) begin
         model_bubble();
      end
   endtask

   vec_t vecs[29];

   initial begin
      // ---------------- reset state ----------------
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_req", {31'd0, i_req}, 32'd0);
      chk("rst_addr", i_address, 32'd0);
      chk("rst_instr", if_id_instr, NOP);
      chk("rst_pc4", if_id_pc4, 32'd0);
      chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst_perf_f", perf_fetched, 32'd0);
      chk("rst_perf_s", perf_stall_cycles, 32'd0);
      $display("reset state checked");

      // ---------------- directed table ----------------
      for (int i = 0; i < 8; i++)
         vecs[i] = mk(1, 0, 0, 0, 0, 0, 1, 32'(i * 4), 1, 32'(i * 4 + 4));
      vecs[8]  = mk(1, 0, 1, 32'h100, 0, 0, 1, 32'h20, 0, 0);           // jump from ID
      vecs[9]  = mk(1, 0, 0, 0, 0, 0, 1, 32'h100, 1, 32'h104);
      vecs[10] = mk(1, 1, 0, 0, 0, 0, 1, 32'h104, 1, 32'h104);          // skid capture
      vecs[11] = mk(1, 1, 0, 0, 0, 0, 0, 32'h108, 1, 32'h104);
      vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 32'h108, 1, 32'h104);
      vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 32'h108, 1, 32'h108);          // skid issued
      vecs[14] = mk(1, 0, 0, 0, 0, 0, 1, 32'h108, 1, 32'h10C);
      vecs[15] = mk(1, 0, 1, 32'h80, 1, 32'h40, 1, 32'h10C, 0, 0);      // EX beats ID
      vecs[16] = mk(1, 0, 0, 0, 0, 0, 1, 32'h40, 1, 32'h44);
      vecs[17] = mk(0, 0, 0, 0, 1, 32'h200, 1, 32'h44, 0, 0);           // redirect, no ack
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
      vecs[19] = mk(1, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
      vecs[20] = mk(1, 0, 0, 0, 0, 0, 1, 32'h200, 1, 32'h204);
      vecs[21] = mk(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h204, 0, 0);    // target masked
      vecs[22] = mk(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);      // pc wrap
      vecs[23] = mk(1, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h4);
      vecs[24] = mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0);                  // bubble
      vecs[25] = mk(0, 1, 0, 0, 0, 0, 1, 32'h4, 0, 0);
      vecs[26] = mk(1, 0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h8);
      vecs[27] = mk(0, 1, 1, 32'h300, 0, 0, 1, 32'h8, 1, 32'h8);        // ID jump ignored in stall
      vecs[28] = mk(1, 0, 0, 0, 0, 0, 1, 32'h8, 1, 32'hC);

      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         drive(vecs[i].ack, vecs[i].stl, vecs[i].idr, vecs[i].idt, vecs[i].exr, vecs[i].ext);
         #1;
         chk($sformatf("vec%0d_req", i), {31'd0, i_req}, {31'd0, vecs[i].req});
         if (vecs[i].req) chk($sformatf("vec%0d_addr", i), i_address, vecs[i].addr);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].valid});
         chk($sformatf("vec%0d_instr", i), if_id_instr,
             vecs[i].valid ? mem_word(vecs[i].pc4 - 32'd4) : NOP);
         if (vecs[i].valid) chk($sformatf("vec%0d_pc4", i), if_id_pc4, vecs[i].pc4);
         $display("vec %0d: ack=%0b stall=%0b addr=%h -> valid=%0b pc4=%h",
                  i, vecs[i].ack, vecs[i].stl, i_address, if_id_valid, if_id_pc4);
      end

      // ---------------- perf counters: 10 fetches + 2 stall cycles ----------------
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(0, 1, 0, 0, 0, 0);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'd10);
      chk("perf_stalls", perf_stall_cycles, 32'd2);
`else
      chk("perf_fetched_off", perf_fetched, 32'd0);
      chk("perf_stalls_off", perf_stall_cycles, 32'd0);
`endif
      $display("perf: fetched=%0d stalls=%0d", perf_fetched, perf_stall_cycles);

      // ---------------- randomized traffic vs reference model ----------------
      do_reset();
      model_reset();
      // The cycle between reset release and the first random cycle is idle.
      model_step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 500; c++) begin
         logic        a, s, idr, exr;
         logic [31:0] idt, ext;
         logic        exp_req;
         logic [31:0] exp_addr;
         @(negedge clk);
         a   = ($urandom_range(99) < 75);
         s   = ($urandom_range(99) < 20);
         idr = ($urandom_range(99) < 8);
         exr = ($urandom_range(99) < 5);
         idt = $urandom;
         ext = (c % 50 == 7) ? 32'hFFFF_FFF8 : $urandom;
         drive(a, s, idr, idt, exr, ext);
         exp_req  = (m_skid_q.size() == 0);
         exp_addr = m_pc;
         #1;
         chk("rnd_req", {31'd0, i_req}, {31'd0, exp_req});
         if (exp_req) chk("rnd_addr", i_address, exp_addr);
         model_step(a, s, idr, idt, exr, ext);
         @(posedge clk);
         #1;
         chk("rnd_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
         chk("rnd_instr", if_id_instr, m_instr);
         if (m_valid) chk("rnd_pc4", if_id_pc4, m_pc4);
`ifdef FETCH_PERF_EN
         chk("rnd_perf_f", perf_fetched, 32'(m_fetched));
         chk("rnd_perf_s", perf_stall_cycles, 32'(m_stalls));
`endif
         $display("rnd %0d: ack=%0b stall=%0b idr=%0b exr=%0b addr=%h -> valid=%0b instr=%h pc4=%h",
                  c, a, s, idr, exr, exp_addr, if_id_valid, if_id_instr, if_id_pc4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined DLX, directly upstream of the instruction decoder.
- Owns the PC and drives instruction-memory requests over a req/ack handshake.
- Loads the IF/ID pipeline register with the instruction word and PC+4.
- Applies stall from the hazard unit and redirects from ID (jumps) and EX (taken branches), squashing wrong-path fetches.
- No delay slot: the instruction after a taken jump or branch is always squashed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, word placed in IF/ID on squash or reset; decodes to I=0 with no side effects.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_req  out  1  fetch request to instruction memory
i_address  out  32  byte address of fetch (word aligned, bits[1:0]=0)
i_ack  in  1  memory has i_data_read valid this cycle
i_data_read  in  32  instruction word
stall  in  1  hazard unit: hold IF/ID and PC
id_redirect  in  1  jump resolved in ID (decoder Pc_cmd_ID path)
id_target  in  32  jump target
ex_redirect  in  1  taken branch resolved in EX
ex_target  in  32  branch target
if_id_instr  out  32  instruction to decoder
if_id_pc4  out  32  PC+4 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction
perf_fetched  out  32  retired-fetch count (optional feature)
perf_stall_cycles  out  32  stall-cycle count (optional feature)

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, state=FETCH, i_req=0.
  - if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, skid empty, perf counters=0.
- Request signals:
  - i_req=1 in FETCH and DISCARD states, deasserted in HELD.
  - i_address=pc. Held stable from i_req rise until the cycle i_ack=1.
  - Zero-wait memory: ack in the same cycle as req, giving 1 instruction per cycle.
- Effective redirect: ex_redirect has priority over id_redirect. id_redirect is ignored while stall=1 (the jump is re-presented once the stall clears). ex_redirect acts regardless of stall.
- FETCH state:
  - ack & no redirect & !stall: IF/ID <= {i_data_read, pc+4, valid=1}; pc <= pc+4.
  - ack & no redirect & stall: skid <= {i_data_read, pc+4}; pc <= pc+4; state <= HELD; IF/ID unchanged.
  - redirect & ack: data dropped; pc <= target; IF/ID <= NOP, valid=0.
  - redirect & !ack: pending target captured; state <= DISCARD; IF/ID <= NOP, valid=0.
  - !ack & no redirect & !stall: IF/ID <= NOP, valid=0 (bubble).
  - !ack & stall: IF/ID held.
- DISCARD state:
  - Waits for ack with i_address still held at the old pc.
  - On ack: data dropped; pc <= pending target; state <= FETCH.
  - A newer redirect during DISCARD overwrites the pending target.
  - IF/ID is NOP until DISCARD exits.
- HELD state (i_req=0):
  - On !stall: IF/ID <= skid with valid=1; state <= FETCH.
  - On ex_redirect: skid dropped; pc <= ex_target; IF/ID <= NOP; state <= FETCH.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0). Target bits[1:0] are forced to 0.
- Reset mid-request: the request is abandoned; memory must tolerate i_req dropping without ack.

Optional Feature:
- FETCH_PERF_EN defined:
  - perf_fetched increments on every IF/ID load with valid=1.
  - perf_stall_cycles increments on every cycle with stall=1.
  - Both counters wrap at 2^32 and clear on reset.
- FETCH_PERF_EN undefined: both outputs are constant 0 and no counter flops are built.

Test Plan:
- Reset release, i_ack tied 1, memory returns addr-based words -> i_address 0,4,8,... on consecutive cycles; if_id_pc4 4,8,12 one cycle after each; if_id_valid=1 from the 2nd cycle.
- stall=1 for 3 cycles with ack=1 -> one skid capture, i_req=0 for the remaining stall cycles, IF/ID unchanged; on release, skid word appears with no address skipped or repeated.
- id_redirect=1, id_target=32'h100 at pc=32'h20 with ack=1 -> IF/ID=NOP valid=0 next cycle; next i_address=32'h100.
- ex_redirect (target 32'h40) and id_redirect (target 32'h80) in the same cycle -> pc=32'h40.
- ex_redirect target 32'h200 while ack held low 2 cycles -> i_address stays at old pc until ack, data discarded, then i_address=32'h200.
- pc=32'hFFFF_FFFC, ack=1 -> next i_address=32'h0, if_id_pc4=32'h0.
- With FETCH_PERF_EN and 10 fetches plus 2 stall cycles -> perf_fetched=10, perf_stall_cycles=2.
